// File: rtl/dct_coeff_packer.sv
// dct_coeff_packer: banked 8x8 coefficient buffer that re-emits blocks
// in zig-zag or raster order on an AXI-stream master with channel tags.
module dct_coeff_packer #(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_CH     = 3,
    parameter int NUM_BANKS  = 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         zigzag_en,
    output logic signed [DATA_WIDTH-1:0] m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tlast,
    output logic                         m_tuser,
    output logic [CH_W-1:0]              m_tid,
    output logic [15:0]                  blocks_out
);

    localparam int BW = $clog2(NUM_BANKS);
    localparam int AW = BW + 6;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    localparam logic [5:0] ZZ_LUT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic signed [DATA_WIDTH-1:0] r_mem [NUM_BANKS*64];
    logic [NUM_BANKS-1:0]         r_full;
    logic [NUM_BANKS-1:0]         r_zz;
    logic [CH_W-1:0]              r_ch [NUM_BANKS];

    logic [5:0]                   r_wr_idx;
    logic [BW-1:0]                r_wr_bank;
    logic [CH_W-1:0]              r_ch_cnt;
    logic                         r_in_ready;

    // Issue pointer runs one beat ahead of the output register;
    // r_rd_bank names the bank whose final beat will release it.
    logic [5:0]                   r_iss_idx;
    logic [BW-1:0]                r_iss_bank;
    logic [BW-1:0]                r_rd_bank;

    logic signed [DATA_WIDTH-1:0] r_tdata;
    logic                         r_tvalid;
    logic                         r_tlast;
    logic                         r_tuser;
    logic [CH_W-1:0]              r_tid;
    logic [15:0]                  r_blocks;

    logic                         w_wr_fire;
    logic                         w_wr_done;
    logic                         w_rel;
    logic                         w_iss;
    logic [NUM_BANKS-1:0]         w_full_nxt;
    logic [BW-1:0]                w_wr_bank_nxt;
    logic [5:0]                   w_rd_idx;
    logic [AW-1:0]                w_rd_addr;

    assign w_wr_fire     = valid_in && r_in_ready;
    assign w_wr_done     = w_wr_fire && (r_wr_idx == 6'd63);
    assign w_rel         = r_tvalid && m_tready && r_tlast;
    assign w_iss         = r_full[r_iss_bank] && (!r_tvalid || m_tready);
    assign w_wr_bank_nxt = r_wr_bank + BW'(w_wr_done);
    assign w_rd_idx      = r_zz[r_iss_bank] ? ZZ_LUT[r_iss_idx] : r_iss_idx;
    assign w_rd_addr     = {r_iss_bank, w_rd_idx};

    // Next-state bank occupancy: set on last write, cleared on last read.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
        if (w_rel)     w_full_nxt[r_rd_bank] = 1'b0;
    end

    // Coefficient storage; stale contents are harmless after reset.
    always_ff @(posedge clk) begin
        if (w_wr_fire) r_mem[{r_wr_bank, r_wr_idx}] <= data_in;
    end

    // Write side: index/bank/channel sequencing and registered in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx   <= '0;
            r_wr_bank  <= '0;
            r_ch_cnt   <= '0;
            r_full     <= '0;
            r_zz       <= '0;
            r_in_ready <= 1'b1;
            for (int i = 0; i < NUM_BANKS; i++) r_ch[i] <= '0;
        end else begin
            r_full     <= w_full_nxt;
            r_in_ready <= !w_full_nxt[w_wr_bank_nxt];
            if (w_wr_fire) begin
                r_wr_idx <= r_wr_idx + 6'd1;
                if (r_wr_idx == 6'd0) begin
                    r_zz[r_wr_bank] <= zigzag_en;
                    r_ch[r_wr_bank] <= r_ch_cnt;
                end
            end
            if (w_wr_done) begin
                r_wr_bank <= w_wr_bank_nxt;
                r_ch_cnt  <= (r_ch_cnt == CH_LAST) ? '0
                                                   : r_ch_cnt + CH_W'(1);
            end
        end
    end

    // Read side: RAM read lands straight in the AXI output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_idx  <= '0;
            r_iss_bank <= '0;
            r_rd_bank  <= '0;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_tlast    <= 1'b0;
            r_tuser    <= 1'b0;
            r_tid      <= '0;
            r_blocks   <= '0;
        end else begin
            if (w_iss) begin
                r_tvalid  <= 1'b1;
                r_tdata   <= r_mem[w_rd_addr];
                r_tlast   <= (r_iss_idx == 6'd63);
                r_tuser   <= (r_iss_idx == 6'd63) &&
                             (r_ch[r_iss_bank] == CH_LAST);
                r_tid     <= r_ch[r_iss_bank];
                r_iss_idx <= r_iss_idx + 6'd1;
                if (r_iss_idx == 6'd63) r_iss_bank <= r_iss_bank + BW'(1);
            end else if (r_tvalid && m_tready) begin
                r_tvalid <= 1'b0;
            end
            if (w_rel) begin
                r_rd_bank <= r_rd_bank + BW'(1);
                r_blocks  <= r_blocks + 16'd1;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign m_tvalid   = r_tvalid;
    assign m_tdata    = r_tdata;
    assign m_tlast    = r_tlast;
    assign m_tuser    = r_tuser;
    assign m_tid      = r_tid;
    assign blocks_out = r_blocks;

endmodule
